// File: rtl/sweep_pkg.sv
// Shared definitions for the frequency sweep sequencer: FSM states,
// signal generator register offsets and AXI4-Lite response codes.
package sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WR_CTRL_ON  = 3'd1,
        ST_WR_FREQ     = 3'd2,
        ST_DWELL       = 3'd3,
        ST_WR_CTRL_OFF = 3'd4,
        ST_ERROR       = 3'd5
    } sweep_state_t;

    localparam logic [31:0] REG_CTRL_OFFSET = 32'h0000_0000;
    localparam logic [31:0] REG_FREQ_OFFSET = 32'h0000_0004;

    localparam logic [31:0] CTRL_OUT_ON  = 32'h0000_0001;
    localparam logic [31:0] CTRL_OUT_OFF = 32'h0000_0000;

    localparam logic [1:0]  RESP_OKAY = 2'b00;

    // Any response other than OKAY aborts the sweep.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/sweep_sequencer_if.sv
// AXI4-Lite write-only channel bundle between the sequencer (master)
// and the signal generator (slave).
interface sweep_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/sweep_sequencer_writer.sv
// Performs exactly one AXI4-Lite write per req pulse. AW and W are raised
// together and each drops on its own handshake; BREADY rises once both
// have completed. ack pulses in the cycle of the B handshake, with resp
// valid alongside it. Only one write may be in flight.
module axil_single_writer #(
    parameter int C_ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [C_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]             req_data,
    output logic                    ack,
    output logic [1:0]              resp,
    sweep_sequencer_if.master       m_axi
);

    logic [C_ADDR_WIDTH-1:0] awaddr_r;
    logic [31:0]             wdata_r;
    logic                    awvalid_r;
    logic                    wvalid_r;
    logic                    bready_r;
    logic                    aw_done_r;
    logic                    w_done_r;
    logic                    aw_hs_s;
    logic                    w_hs_s;
    logic                    b_hs_s;

    assign aw_hs_s = awvalid_r & m_axi.awready;
    assign w_hs_s  = wvalid_r & m_axi.wready;
    assign b_hs_s  = bready_r & m_axi.bvalid;

    assign ack  = b_hs_s;
    assign resp = m_axi.bresp;

    assign m_axi.awaddr  = awaddr_r;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_r;
    assign m_axi.wdata   = wdata_r;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid_r;
    assign m_axi.bready  = bready_r;

    // Channel handshake tracking; a new req may land in the same cycle as the B handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awaddr_r  <= {C_ADDR_WIDTH{1'b0}};
            wdata_r   <= 32'h0000_0000;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                awvalid_r <= 1'b0;
                aw_done_r <= 1'b1;
            end
            if (w_hs_s) begin
                wvalid_r <= 1'b0;
                w_done_r <= 1'b1;
            end
            if (b_hs_s) begin
                bready_r  <= 1'b0;
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
            end else if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
                bready_r <= 1'b1;
            end
            if (req) begin
                awaddr_r  <= req_addr;
                wdata_r   <= req_data;
                awvalid_r <= 1'b1;
                wvalid_r  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sweep_sequencer.sv
// Steps a signal generator through f_start, f_start+f_step, ... up to
// f_stop, holding each frequency for 'dwell' cycles. The output is
// enabled after the first frequency write and disabled at sweep end.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter logic [31:0] C_GEN_BASEADDR     = 32'h43C0_0000,
    parameter int          C_DWELL_WIDTH      = 24,
    parameter int          C_M_AXI_ADDR_WIDTH = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     loop_en,
    input  logic [31:0]              f_start,
    input  logic [31:0]              f_stop,
    input  logic [31:0]              f_step,
    input  logic [C_DWELL_WIDTH-1:0] dwell,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    sweep_sequencer_if.master        M_AXI
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] CTRL_ADDR = AW'(C_GEN_BASEADDR + REG_CTRL_OFFSET);
    localparam logic [AW-1:0] FREQ_ADDR = AW'(C_GEN_BASEADDR + REG_FREQ_OFFSET);
    localparam logic [C_DWELL_WIDTH-1:0] DWELL_ONE = C_DWELL_WIDTH'(1);

    sweep_state_t             state_r, state_n_s;
    logic [31:0]              cur_r, cur_n_s;
    logic [31:0]              f_start_r, f_stop_r, f_step_r;
    logic [C_DWELL_WIDTH-1:0] dwell_r, cnt_r, cnt_n_s, dwell_eff_s;
    logic                     first_r, first_n_s;
    logic                     abort_pend_r, abort_pend_n_s;
    logic                     err_r, err_n_s;
    logic                     busy_r, done_r;
    logic [32:0]              next_s;
    logic                     sweep_end_s;
    logic                     dwell_last_s;

    logic                     wr_req_s;
    logic [AW-1:0]            wr_addr_s;
    logic [31:0]              wr_data_s;
    logic                     wr_ack_s;
    logic [1:0]               wr_resp_s;

    // 33-bit sum so a carry out of the frequency word ends the sweep instead of wrapping.
    assign next_s       = {1'b0, cur_r} + {1'b0, f_step_r};
    assign sweep_end_s  = next_s[32] | (next_s[31:0] > f_stop_r);
    assign dwell_eff_s  = (dwell_r == {C_DWELL_WIDTH{1'b0}}) ? DWELL_ONE : dwell_r;
    assign dwell_last_s = (cnt_r >= (dwell_eff_s - DWELL_ONE));

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

    axil_single_writer #(
        .C_ADDR_WIDTH (AW)
    ) u_writer (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .req      (wr_req_s),
        .req_addr (wr_addr_s),
        .req_data (wr_data_s),
        .ack      (wr_ack_s),
        .resp     (wr_resp_s),
        .m_axi    (M_AXI)
    );

    // Next-state logic; each write is requested on the transition into its state.
    always_comb begin
        state_n_s      = state_r;
        cur_n_s        = cur_r;
        cnt_n_s        = cnt_r;
        first_n_s      = first_r;
        abort_pend_n_s = abort_pend_r;
        err_n_s        = err_r;
        wr_req_s       = 1'b0;
        wr_addr_s      = FREQ_ADDR;
        wr_data_s      = cur_r;
        case (state_r)
            ST_IDLE: begin
                abort_pend_n_s = 1'b0;
                if (start) begin
                    cur_n_s   = f_start;
                    first_n_s = 1'b1;
                    state_n_s = ST_WR_FREQ;
                    wr_req_s  = 1'b1;
                    wr_addr_s = FREQ_ADDR;
                    wr_data_s = f_start;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WR_FREQ, ST_WR_CTRL_ON: begin
                if (abort) begin
                    abort_pend_n_s = 1'b1;
                end else begin
                    abort_pend_n_s = abort_pend_r;
                end
                if (wr_ack_s) begin
                    if (resp_is_error(wr_resp_s)) begin
                        err_n_s   = 1'b1;
                        state_n_s = ST_ERROR;
                    end else if (abort | abort_pend_r) begin
                        state_n_s = ST_WR_CTRL_OFF;
                        wr_req_s  = 1'b1;
                        wr_addr_s = CTRL_ADDR;
                        wr_data_s = CTRL_OUT_OFF;
                    end else if ((state_r == ST_WR_FREQ) && first_r) begin
                        state_n_s = ST_WR_CTRL_ON;
                        wr_req_s  = 1'b1;
                        wr_addr_s = CTRL_ADDR;
                        wr_data_s = CTRL_OUT_ON;
                    end else begin
                        first_n_s = 1'b0;
                        cnt_n_s   = {C_DWELL_WIDTH{1'b0}};
                        state_n_s = ST_DWELL;
                    end
                end else begin
                    state_n_s = state_r;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_n_s = ST_WR_CTRL_OFF;
                    wr_req_s  = 1'b1;
                    wr_addr_s = CTRL_ADDR;
                    wr_data_s = CTRL_OUT_OFF;
                end else if (dwell_last_s) begin
                    if (sweep_end_s) begin
                        if (loop_en) begin
                            cur_n_s   = f_start_r;
                            state_n_s = ST_WR_FREQ;
                            wr_req_s  = 1'b1;
                            wr_addr_s = FREQ_ADDR;
                            wr_data_s = f_start_r;
                        end else begin
                            state_n_s = ST_WR_CTRL_OFF;
                            wr_req_s  = 1'b1;
                            wr_addr_s = CTRL_ADDR;
                            wr_data_s = CTRL_OUT_OFF;
                        end
                    end else begin
                        cur_n_s   = next_s[31:0];
                        state_n_s = ST_WR_FREQ;
                        wr_req_s  = 1'b1;
                        wr_addr_s = FREQ_ADDR;
                        wr_data_s = next_s[31:0];
                    end
                end else begin
                    cnt_n_s = cnt_r + DWELL_ONE;
                end
            end
            ST_WR_CTRL_OFF: begin
                if (wr_ack_s) begin
                    if (resp_is_error(wr_resp_s)) begin
                        err_n_s   = 1'b1;
                        state_n_s = ST_ERROR;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    state_n_s = ST_WR_CTRL_OFF;
                end
            end
            ST_ERROR: begin
                if (start) begin
                    err_n_s   = 1'b0;
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_ERROR;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State, sweep parameters and registered status outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r      <= ST_IDLE;
            cur_r        <= 32'h0000_0000;
            cnt_r        <= {C_DWELL_WIDTH{1'b0}};
            first_r      <= 1'b0;
            abort_pend_r <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            f_start_r    <= 32'h0000_0000;
            f_stop_r     <= 32'h0000_0000;
            f_step_r     <= 32'h0000_0000;
            dwell_r      <= {C_DWELL_WIDTH{1'b0}};
        end else begin
            state_r      <= state_n_s;
            cur_r        <= cur_n_s;
            cnt_r        <= cnt_n_s;
            first_r      <= first_n_s;
            abort_pend_r <= abort_pend_n_s;
            err_r        <= err_n_s;
            busy_r       <= (state_n_s != ST_IDLE) && (state_n_s != ST_ERROR);
            done_r       <= (state_r == ST_WR_CTRL_OFF) && (state_n_s == ST_IDLE);
            if ((state_r == ST_IDLE) && start) begin
                f_start_r <= f_start;
                f_stop_r  <= f_stop;
                f_step_r  <= f_step;
                dwell_r   <= dwell;
            end
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer with a reactive AXI4-Lite slave that
// logs every completed write and flags unstable or duplicated channel traffic.
module tb_sweep_sequencer;

    localparam logic [31:0] BASE   = 32'h43C0_0000;
    localparam logic [31:0] CTRL_A = BASE;
    localparam logic [31:0] FREQ_A = BASE + 32'h0000_0004;

    logic        ACLK    = 1'b0;
    logic        ARESETN = 1'b1;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic        loop_en = 1'b0;
    logic [31:0] f_start = 32'h0;
    logic [31:0] f_stop  = 32'h0;
    logic [31:0] f_step  = 32'h0;
    logic [23:0] dwell   = 24'h0;
    logic        busy, done, err;

    sweep_sequencer_if #(.ADDR_WIDTH(32)) axi ();

    sweep_sequencer #(
        .C_GEN_BASEADDR     (32'h43C0_0000),
        .C_DWELL_WIDTH      (24),
        .C_M_AXI_ADDR_WIDTH (32)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .start   (start),
        .abort   (abort),
        .loop_en (loop_en),
        .f_start (f_start),
        .f_stop  (f_stop),
        .f_step  (f_step),
        .dwell   (dwell),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .M_AXI   (axi)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    // slave configuration (written by the main process only)
    int aw_delay   = 0;
    int w_delay    = 0;
    bit w_after_aw = 1'b0;
    int err_idx    = -1;

    // monitor state (written by the monitor only)
    bit          aw_seen = 1'b0;
    bit          w_seen  = 1'b0;
    logic [31:0] aw_addr_q, w_data_q;
    int          n_wr     = 0;
    int          stab_err = 0;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    bit          prev_aw_wait = 1'b0;
    bit          prev_w_wait  = 1'b0;
    logic [31:0] prev_awaddr, prev_wdata;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel monitor: records handshakes and checks that pending AW/W stay stable.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_seen      = 1'b0;
            w_seen       = 1'b0;
            prev_aw_wait = 1'b0;
            prev_w_wait  = 1'b0;
        end else begin
            if (prev_aw_wait && (!axi.awvalid || axi.awaddr !== prev_awaddr)) stab_err++;
            if (prev_w_wait && (!axi.wvalid || axi.wdata !== prev_wdata)) stab_err++;
            prev_aw_wait = axi.awvalid && !axi.awready;
            prev_w_wait  = axi.wvalid && !axi.wready;
            prev_awaddr  = axi.awaddr;
            prev_wdata   = axi.wdata;
            if (axi.awvalid && axi.awready) begin
                if (aw_seen) stab_err++;
                aw_seen   = 1'b1;
                aw_addr_q = axi.awaddr;
            end
            if (axi.wvalid && axi.wready) begin
                if (w_seen) stab_err++;
                w_seen   = 1'b1;
                w_data_q = axi.wdata;
            end
            if (axi.bvalid && axi.bready) begin
                log_addr[n_wr % 64] = aw_addr_q;
                log_data[n_wr % 64] = w_data_q;
                n_wr++;
                aw_seen = 1'b0;
                w_seen  = 1'b0;
            end
        end
    end

    // Slave driver: updates ready/valid on the falling edge.
    initial begin
        int aw_wait = 0;
        int w_wait  = 0;
        int b_idx   = 0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                aw_wait = 0;
                w_wait  = 0;
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                axi.bvalid  = 1'b0;
                axi.bresp   = 2'b00;
            end else begin
                if (axi.awvalid && !aw_seen) begin
                    aw_wait++;
                    axi.awready = (aw_wait > aw_delay);
                end else begin
                    aw_wait = 0;
                    axi.awready = 1'b0;
                end
                if (axi.wvalid && !w_seen && (aw_seen || !w_after_aw)) begin
                    w_wait++;
                    axi.wready = (w_wait > w_delay);
                end else begin
                    w_wait = 0;
                    axi.wready = 1'b0;
                end
                if (axi.bvalid) begin
                    if (n_wr != b_idx) begin
                        axi.bvalid = 1'b0;
                        axi.bresp  = 2'b00;
                    end
                end else if (aw_seen && w_seen) begin
                    axi.bvalid = 1'b1;
                    b_idx      = n_wr;
                    axi.bresp  = (n_wr == err_idx) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    task automatic pulse_start(input string tag, input bit exp_aw);
        @(negedge ACLK);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        check_val({tag, "_aw_latency"}, {63'd0, axi.awvalid}, {63'd0, exp_aw});
        @(negedge ACLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int nd  = 0;
        int cyc = 0;
        while (cyc < budget && !(nd > 0 && !busy)) begin
            @(negedge ACLK);
            cyc++;
            if (done) nd++;
        end
        check_val({tag, "_finished"}, {63'd0, (nd > 0 && !busy)}, 64'd1);
        repeat (5) begin
            @(negedge ACLK);
            if (done) nd++;
        end
        check_val({tag, "_done_cnt"}, 64'(nd), 64'd1);
        check_val({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int cyc = 0;
        while (cyc < budget && n_wr < target) begin
            @(negedge ACLK);
            cyc++;
        end
        check_val(tag, {63'd0, (n_wr >= target)}, 64'd1);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        check_val($sformatf("%s_wr%0d_addr", tag, idx), {32'd0, log_addr[idx % 64]}, {32'd0, a});
        check_val($sformatf("%s_wr%0d_data", tag, idx), {32'd0, log_data[idx % 64]}, {32'd0, d});
    endtask

    task automatic setup(input logic [31:0] fs, input logic [31:0] fstep, input logic [31:0] fstop,
                         input logic [23:0] dw, input logic le);
        f_start = fs;
        f_step  = fstep;
        f_stop  = fstop;
        dwell   = dw;
        loop_en = le;
    endtask

    initial begin
        int base;
        bit saw_aw;

        // reset
        #1 ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        check_val("rst_busy",    {63'd0, busy},        64'd0);
        check_val("rst_done",    {63'd0, done},        64'd0);
        check_val("rst_err",     {63'd0, err},         64'd0);
        check_val("rst_awvalid", {63'd0, axi.awvalid}, 64'd0);
        check_val("rst_wvalid",  {63'd0, axi.wvalid},  64'd0);
        check_val("rst_bready",  {63'd0, axi.bready},  64'd0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // abort while idle is ignored
        abort = 1'b1;
        @(negedge ACLK);
        abort = 1'b0;
        repeat (3) @(negedge ACLK);
        check_val("idle_abort_busy", {63'd0, busy}, 64'd0);
        check_val("idle_abort_aw",   {63'd0, axi.awvalid}, 64'd0);

        // basic sweep 100..250 step 50
        base = n_wr;
        setup(32'd100, 32'd50, 32'd250, 24'd4, 1'b0);
        pulse_start("t1", 1'b1);
        check_val("t1_busy_high", {63'd0, busy}, 64'd1);
        wait_done("t1", 1000);
        check_val("t1_nwr", 64'(n_wr - base), 64'd6);
        check_wr("t1", base + 0, FREQ_A, 32'd100);
        check_wr("t1", base + 1, CTRL_A, 32'd1);
        check_wr("t1", base + 2, FREQ_A, 32'd150);
        check_wr("t1", base + 3, FREQ_A, 32'd200);
        check_wr("t1", base + 4, FREQ_A, 32'd250);
        check_wr("t1", base + 5, CTRL_A, 32'd0);

        // W ready three cycles after AW handshake
        base = n_wr;
        aw_delay = 0; w_delay = 2; w_after_aw = 1'b1;
        setup(32'd10, 32'd5, 32'd15, 24'd1, 1'b0);
        pulse_start("t2", 1'b1);
        wait_done("t2", 1000);
        check_val("t2_nwr", 64'(n_wr - base), 64'd4);
        check_wr("t2", base + 0, FREQ_A, 32'd10);
        check_wr("t2", base + 1, CTRL_A, 32'd1);
        check_wr("t2", base + 2, FREQ_A, 32'd15);
        check_wr("t2", base + 3, CTRL_A, 32'd0);
        check_val("t2_stability", 64'(stab_err), 64'd0);

        // overflow at top of range, W before AW, dwell=0
        base = n_wr;
        aw_delay = 2; w_delay = 0; w_after_aw = 1'b0;
        setup(32'hFFFF_FFF0, 32'd32, 32'hFFFF_FFFF, 24'd0, 1'b0);
        pulse_start("t3", 1'b1);
        wait_done("t3", 1000);
        check_val("t3_nwr", 64'(n_wr - base), 64'd3);
        check_wr("t3", base + 0, FREQ_A, 32'hFFFF_FFF0);
        check_wr("t3", base + 1, CTRL_A, 32'd1);
        check_wr("t3", base + 2, CTRL_A, 32'd0);
        aw_delay = 0;

        // looping sweep, abort in the second dwell at 200
        base = n_wr;
        setup(32'd100, 32'd100, 32'd200, 24'd20, 1'b1);
        pulse_start("t4", 1'b1);
        wait_writes("t4_reach_loop", base + 5, 2000);
        repeat (5) @(negedge ACLK);
        check_val("t4_busy_in_dwell", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        @(negedge ACLK);
        abort = 1'b0;
        wait_done("t4", 1000);
        check_val("t4_nwr", 64'(n_wr - base), 64'd6);
        check_wr("t4", base + 2, FREQ_A, 32'd200);
        check_wr("t4", base + 3, FREQ_A, 32'd100);
        check_wr("t4", base + 4, FREQ_A, 32'd200);
        check_wr("t4", base + 5, CTRL_A, 32'd0);
        loop_en = 1'b0;

        // SLVERR on the second write
        base = n_wr;
        err_idx = base + 1;
        setup(32'd100, 32'd50, 32'd250, 24'd4, 1'b0);
        pulse_start("t5", 1'b1);
        wait_writes("t5_two_writes", base + 2, 500);
        saw_aw = 1'b0;
        repeat (30) begin
            @(negedge ACLK);
            if (axi.awvalid) saw_aw = 1'b1;
        end
        check_val("t5_err",      {63'd0, err},    64'd1);
        check_val("t5_busy",     {63'd0, busy},   64'd0);
        check_val("t5_no_aw",    {63'd0, saw_aw}, 64'd0);
        check_val("t5_nwr",      64'(n_wr - base), 64'd2);
        err_idx = -1;
        pulse_start("t5_clear", 1'b0);
        repeat (2) @(negedge ACLK);
        check_val("t5_err_clr",  {63'd0, err},  64'd0);
        check_val("t5_busy_clr", {63'd0, busy}, 64'd0);

        // reset while AWVALID is pending
        aw_delay = 20;
        setup(32'd100, 32'd50, 32'd250, 24'd4, 1'b0);
        pulse_start("t6", 1'b1);
        repeat (2) @(negedge ACLK);
        check_val("t6_aw_pending", {63'd0, axi.awvalid}, 64'd1);
        #2 ARESETN = 1'b0;
        #1;
        check_val("t6_aw_async",  {63'd0, axi.awvalid}, 64'd0);
        check_val("t6_w_async",   {63'd0, axi.wvalid},  64'd0);
        check_val("t6_busy_async", {63'd0, busy},       64'd0);
        base = n_wr;
        @(negedge ACLK);
        ARESETN = 1'b1;
        aw_delay = 0;
        saw_aw = 1'b0;
        repeat (20) begin
            @(negedge ACLK);
            if (axi.awvalid) saw_aw = 1'b1;
        end
        check_val("t6_no_resume", {63'd0, saw_aw}, 64'd0);
        check_val("t6_nwr",       64'(n_wr - base), 64'd0);
        check_val("t6_busy_idle", {63'd0, busy}, 64'd0);
        check_val("final_stability", 64'(stab_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
